// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and segment decode for the FND scan controller
//
// Purpose: active-low 7-segment codes {dp,g,f,e,d,c,b,a} for decimal digits,
//          the blank code, the digit count and the BCD FSM state type.
// Ports:   none (package).
package fnd_pkg;

    localparam int DIGIT_N = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } bcd_state_e;

    // Non-decimal nibbles cannot come out of the converter; show them dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// rtl/fnd_scan_ctrl_if.sv - value/display bundle between the adder side and the FND controller
//
// Purpose: groups the binary value input with the busy flag and FND drive outputs.
// Signals: value     W  binary value to display ({carry, sum})
//          busy      1  BCD conversion in progress
//          fnd_digit 4  active-low one-hot digit enables, bit0 = ones
//          fnd_data  8  active-low segments {dp,g,f,e,d,c,b,a}
// Modports: master = value producer / display observer, slave = the controller.
interface fnd_scan_ctrl_if #(
    parameter int W = 9
);
    logic [W-1:0] value;
    logic         busy;
    logic [3:0]   fnd_digit;
    logic [7:0]   fnd_data;

    modport master (
        output value,
        input  busy,
        input  fnd_digit,
        input  fnd_data
    );

    modport slave (
        input  value,
        output busy,
        output fnd_digit,
        output fnd_data
    );

endinterface

// File: rtl/fnd_bcd_seq.sv
// rtl/fnd_bcd_seq.sv - sequential double-dabble binary to 4-digit BCD converter
//
// Purpose: watches value_i; on a change runs W shift-add-3 iterations and then
//          publishes all four BCD nibbles at once on disp_bcd_o.
// Ports:   clk        in  1   rising-edge clock
//          reset      in  1   synchronous, active-low
//          value_i    in  W   binary value
//          disp_bcd_o out 16  published BCD, nibble 0 = ones
//          busy_o     out 1   high in CONV and LOAD
module fnd_bcd_seq
    import fnd_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] value_i,
    output logic [15:0]  disp_bcd_o,
    output logic         busy_o
);

    localparam int IW = $clog2(W + 1);

    bcd_state_e   state_q, state_d;
    logic [W-1:0] shreg_q, shreg_d;
    logic [W-1:0] last_q,  last_d;
    logic [15:0]  bcd_q,   bcd_d;
    logic [15:0]  disp_q,  disp_d;
    logic [IW-1:0] iter_q, iter_d;

    logic [15:0]  bcd_adj;
    logic         unused_bcd_msb;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < DIGIT_N; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    // Bit 15 would be shifted out; it stays zero for any value that fits 9999.
    assign unused_bcd_msb = bcd_adj[15];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (value_i != last_q) begin
                    shreg_d = value_i;
                    last_d  = value_i;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // The terminal check takes its own cycle, so CONV lasts W+1 cycles.
                if (iter_q == IW'(W)) begin
                    state_d = ST_LOAD;
                end else begin
                    bcd_d   = {bcd_adj[14:0], shreg_q[W-1]};
                    shreg_d = shreg_q << 1;
                    iter_d  = iter_q + 1'b1;
                end
            end
            ST_LOAD: begin
                disp_d  = bcd_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            last_q  <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            iter_q  <= iter_d;
        end
    end

    assign disp_bcd_o = disp_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit common-anode FND controller with BCD conversion and scan
//
// Purpose: converts bus.value to BCD via fnd_bcd_seq and time-multiplexes the
//          four digits, one slot per TICK_DIV clocks, with optional leading-zero blanking.
// Ports:   clk    in   1  rising-edge clock
//          reset  in   1  synchronous, active-low
//          bus    slave modport: value in, busy / fnd_digit / fnd_data out
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int W        = 9,
    parameter int TICK_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic           clk,
    input  logic           reset,
    fnd_scan_ctrl_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [15:0]   disp_bcd;
    logic          busy;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    digit_q, digit_d;
    logic [7:0]    data_q, data_d;

    logic          tick;
    logic [3:0]    nib;
    logic [15:0]   upper;
    logic          lz_blank;
    logic [7:0]    seg_sel;

    fnd_bcd_seq #(
        .W (W)
    ) u_bcd_seq (
        .clk        (clk),
        .reset      (reset),
        .value_i    (bus.value),
        .disp_bcd_o (disp_bcd),
        .busy_o     (busy)
    );

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    // Digit k is blanked when it and every more significant nibble are zero.
    always_comb begin
        nib      = disp_bcd[{idx_q, 2'b00} +: 4];
        upper    = disp_bcd >> {idx_q, 2'b00};
        lz_blank = (BLANK_LZ != 0) && (idx_q != 2'd0) && (upper == 16'd0);
        seg_sel  = lz_blank ? SEG_BLANK : seg_decode(nib);
    end

    // Outputs are sampled only on tick, so a new disp_bcd never glitches a slot.
    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        idx_d      = idx_q;
        digit_d    = digit_q;
        data_d     = data_q;
        if (tick) begin
            tick_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
            digit_d    = ~(4'b0001 << idx_q);
            data_d     = seg_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            idx_q      <= '0;
            digit_q    <= 4'b1111;
            data_q     <= SEG_BLANK;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            idx_q      <= idx_d;
            digit_q    <= digit_d;
            data_q     <= data_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.fnd_digit = digit_q;
    assign bus.fnd_data  = data_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - directed self-checking bench for fnd_scan_ctrl (W=9, TICK_DIV=4)
module tb_fnd_scan_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0] frame [4];
    logic [3:0] seen;

    fnd_scan_ctrl_if #(.W(9)) bus ();

    fnd_scan_ctrl #(
        .W        (9),
        .TICK_DIV (4),
        .BLANK_LZ (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records the segment code seen for each digit over a full scan.
    task automatic capture_frame();
        seen = 4'b0000;
        for (int d = 0; d < 4; d++) frame[d] = 8'h00;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            case (bus.fnd_digit)
                4'b1110: begin frame[0] = bus.fnd_data; seen[0] = 1'b1; end
                4'b1101: begin frame[1] = bus.fnd_data; seen[1] = 1'b1; end
                4'b1011: begin frame[2] = bus.fnd_data; seen[2] = 1'b1; end
                4'b0111: begin frame[3] = bus.fnd_data; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // Length of the next busy run, 0 if none starts within the budget.
    task automatic busy_run(output int len);
        len = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.busy) len++;
            else if (len > 0) break;
        end
    endtask

    task automatic test_reset();
        int k_found;
        reset = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.fnd_digit !== 4'b1111) begin
            failures++;
            $display("FAIL reset_digit actual=%b required=1111", bus.fnd_digit);
        end
        checks++;
        if (bus.fnd_data !== 8'hFF) begin
            failures++;
            $display("FAIL reset_data actual=%h required=ff", bus.fnd_data);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy actual=%b required=0", bus.busy);
        end
        reset = 1'b1;
        k_found = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.fnd_digit === 4'b1110) begin
                k_found = k;
                break;
            end
        end
        checks++;
        if (k_found != 4) begin
            failures++;
            $display("FAIL first_digit_latency actual=%0d required=4", k_found);
        end
        checks++;
        if (bus.fnd_data !== 8'hC0) begin
            failures++;
            $display("FAIL first_digit_data actual=%h required=c0", bus.fnd_data);
        end
    endtask

    task automatic test_value(input logic [8:0] v, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        int len;
        logic [7:0] exp_seg [4];
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        @(negedge clk);
        bus.value = v;
        busy_run(len);
        checks++;
        if (len != 11) begin
            failures++;
            $display("FAIL busy_len value=%0d actual=%0d required=11", v, len);
        end
        capture_frame();
        checks++;
        if (seen !== 4'b1111) begin
            failures++;
            $display("FAIL scan_seen value=%0d actual=%b required=1111", v, seen);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame[d] !== exp_seg[d]) begin
                failures++;
                $display("FAIL digit%0d value=%0d actual=%h required=%h", d, v, frame[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_conv_255();
        test_value(9'd255, 8'h92, 8'h92, 8'hA4, 8'hFF);
    endtask

    task automatic test_conv_510_and_zero();
        test_value(9'd510, 8'hC0, 8'hF9, 8'h92, 8'hFF);
        test_value(9'd0,   8'hC0, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic test_change_during_conv();
        int len1;
        int len2;
        logic [7:0] exp_seg [4];
        exp_seg[0] = 8'hC0; exp_seg[1] = 8'hC0; exp_seg[2] = 8'hB0; exp_seg[3] = 8'hFF;
        @(negedge clk);
        bus.value = 9'd7;
        len1 = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 3) bus.value = 9'd300;
            if (bus.busy) len1++;
            else if (len1 > 0) break;
        end
        busy_run(len2);
        checks++;
        if (len1 != 11) begin
            failures++;
            $display("FAIL first_conv_len actual=%0d required=11", len1);
        end
        checks++;
        if (len2 != 11) begin
            failures++;
            $display("FAIL reconv_len actual=%0d required=11", len2);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame[d] !== exp_seg[d]) begin
                failures++;
                $display("FAIL late_digit%0d actual=%h required=%h", d, frame[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        int busy_cycles;
        logic [7:0] exp_seg [4];
        exp_seg[0] = 8'hC0; exp_seg[1] = 8'hFF; exp_seg[2] = 8'hFF; exp_seg[3] = 8'hFF;
        @(negedge clk);
        bus.value = 9'd123;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        bus.value = 9'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.fnd_digit !== 4'b1111 || bus.fnd_data !== 8'hFF) begin
            failures++;
            $display("FAIL midconv_reset_outputs actual=%b/%b/%h required=0/1111/ff",
                     bus.busy, bus.fnd_digit, bus.fnd_data);
        end
        reset = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 0) begin
            failures++;
            $display("FAIL idle_after_reset busy_cycles actual=%0d required=0", busy_cycles);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame[d] !== exp_seg[d]) begin
                failures++;
                $display("FAIL post_reset_digit%0d actual=%h required=%h", d, frame[d], exp_seg[d]);
            end
        end
        test_value(9'd42, 8'hA4, 8'h99, 8'hFF, 8'hFF);
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] exp_dig;
        bit synced;
        synced = 1'b0;
        prev = bus.fnd_digit;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.fnd_digit === 4'b1110 && prev !== 4'b1110) begin
                synced = 1'b1;
                break;
            end
            prev = bus.fnd_digit;
        end
        checks++;
        if (!synced) begin
            failures++;
            $display("FAIL scan_sync actual=%b required=1110", bus.fnd_digit);
        end else begin
            for (int i = 0; i < 160; i++) begin
                if (i > 0) @(negedge clk);
                exp_dig = ~(4'b0001 << ((i / 4) % 4));
                checks++;
                if (bus.fnd_digit !== exp_dig || $countones(~bus.fnd_digit) != 1) begin
                    failures++;
                    $display("FAIL scan_cycle%0d actual=%b required=%b", i, bus.fnd_digit, exp_dig);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus.value = '0;
        test_reset();
        test_conv_255();
        test_conv_510_and_zero();
        test_change_during_conv();
        test_reset_mid_conv();
        test_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
